// File: rtl/calc_core_seq.sv
// calc_core_seq: multi-cycle unsigned add/sub/mul/div core with a start/busy/done handshake
// Ports: CLK100MHZ clock, CPU_RESETN async active-low reset; start/op/a/b request an operation
//        (op 00 add, 01 sub, 10 mul, 11 div); busy/done handshake; result, remainder, carry
//        and err_div0 are registered and hold until the next operation completes.
module calc_core_seq #(
    parameter int WIDTH = 8
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   remainder,
    output logic               carry,
    output logic               err_div0
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, ADDSUB, ITER, FINISH} state_t;
    state_t state, state_nx;
    // op[0] alone separates sub from add and div from mul once the path is chosen
    logic               sel;
    logic [WIDTH-1:0]   ra, rb, rem;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic               c_r, e_r, last;
    logic [WIDTH:0]     add_sum, mul_sum, shifted, trial;
    assign busy    = state != IDLE;
    assign last    = cnt == CW'(WIDTH - 1);
    assign add_sum = {1'b0, ra} + {1'b0, rb};
    // mul: acc upper half accumulates, lower half holds the not-yet-used multiplier bits
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ra} : '0);
    // div: acc lower half shifts the dividend out and the quotient in; trial[WIDTH] set means restore
    assign shifted = {rem, acc[WIDTH-1]};
    assign trial   = shifted - {1'b0, rb};
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= IDLE;
        else             state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !start ? IDLE : !op[1] ? ADDSUB : (op[0] && b == '0) ? FINISH : ITER;
            ADDSUB:  state_nx = FINISH;
            ITER:    state_nx = last ? FINISH : ITER;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sel       <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            rem       <= '0;
            cnt       <= '0;
            acc       <= '0;
            c_r       <= 1'b0;
            e_r       <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            carry     <= 1'b0;
            err_div0  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sel <= op[0];
                    ra  <= a;
                    rb  <= b;
                    rem <= '0;
                    cnt <= '0;
                    c_r <= 1'b0;
                    e_r <= op == 2'b11 && b == '0;
                    acc <= {{WIDTH{1'b0}}, op[0] ? a : b};
                end
                ADDSUB: begin
                    acc <= sel ? {{WIDTH{1'b0}}, ra - rb} : {{(WIDTH-1){1'b0}}, add_sum};
                    c_r <= sel ? ra < rb : add_sum[WIDTH];
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    acc <= sel ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~trial[WIDTH]}
                               : {mul_sum, acc[WIDTH-1:1]};
                    rem <= !sel ? rem : trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                end
                default: begin
                    result    <= e_r ? '0 : acc;
                    remainder <= rem;
                    carry     <= c_r;
                    err_div0  <= e_r;
                    done      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/calc_core_seq.md
# calc_core_seq

Parametrised, multi-cycle arithmetic core for the calculator. It supports add, subtract, multiply and divide on unsigned `WIDTH`-bit operands. Multiply and divide are iterative, one bit per clock, so the core scales in width without wide combinational multipliers or dividers. The core sits between the switch/button input capture and the seven-segment/LED display logic. It uses a start/busy/done handshake, and its flags let the display layer show carry, borrow and divide-by-zero (`dEAd`).

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 4..32.
- `CPU_RESETN`, default n/a: not a parameter. Listed here so the reset polarity is explicit.

Ports:
- `CLK100MHZ`  in  1  system clock; all state changes on its rising edge.
- `CPU_RESETN`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- `a`  in  WIDTH  operand A (dividend / minuend).
- `b`  in  WIDTH  operand B (divisor / subtrahend).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when results become valid.
- `result`  out  2*WIDTH  sum / difference / product / quotient, zero-extended.
- `remainder`  out  WIDTH  division remainder; 0 for other ops.
- `carry`  out  1  carry-out on add; borrow (a<b) on sub; 0 otherwise.
- `err_div0`  out  1  set when div is requested with b==0.

## Operation
- States: IDLE, ADDSUB, ITER, FINISH.
- IDLE:
  - `start`=1 latches `a`, `b` and `op` into internal registers and clears the iteration counter.
  - add/sub → ADDSUB.
  - mul → ITER.
  - div with b≠0 → ITER.
  - div with b==0 → FINISH with the error path selected.
- ADDSUB: computes once and goes to FINISH.
  - add: result = zero-extend(a+b) in low WIDTH+1 bits; carry = bit WIDTH.
  - sub: result low WIDTH bits = (a−b) mod 2^WIDTH, upper bits 0; carry = (a<b).
- ITER, mul: shift-add over the latched B, one multiplier bit per cycle, LSB first. Runs exactly WIDTH cycles; the accumulator is 2*WIDTH bits and never overflows.
- ITER, div: restoring division, one quotient bit per cycle, MSB first. Runs exactly WIDTH cycles; the partial remainder is WIDTH+1 bits.
- FINISH:
  - registers `result`, `remainder`, `carry` and `err_div0`.
  - pulses `done` for one cycle.
  - returns to IDLE.
- Divide by zero: result=0, remainder=0, carry=0, err_div0=1.
- Error handling: `err_div0` clears only when a later operation completes or on reset.
- Output holding: outputs keep their last values until the next FINISH. Changes on `a`, `b` or `op` while busy have no effect.
- `start` while busy is ignored; no queueing.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `remainder`=0, `carry`=0, `err_div0`=0; state IDLE.
- Reset assertion takes effect immediately, including mid-operation; the in-flight operation is discarded and `done` is not pulsed.
- Latency, counting rising edge 0 as the edge that samples `start`; `done` is high in the cycle after edge L:
  - add/sub: L=2.
  - div by zero: L=1.
  - mul and div (b≠0): L=WIDTH+1.
- `result`, `remainder` and the flags become valid at edge L, in the same cycle `done` goes high.
- `busy` rises at edge 0 and falls at edge L, together with the `done` pulse.
- A new `start` is accepted at edge L+1 at the earliest. The back-to-back throughput limit is one operation per L+1 cycles.
- `start` held high continuously issues a new operation each time IDLE is reached. It is not edge-detected; debouncing and edge detection belong to the input stage.

## Test plan
All scenarios use WIDTH=8.
- Reset, then a=0x0A, b=0x03, op=add, start pulse → `done` after L=2; result=0x000D, carry=0, err_div0=0.
- Subtraction:
  - a=0x0A, b=0x03, sub → result=0x0007, carry=0.
  - a=0x03, b=0x0A, sub → result=0x00F9, carry=1.
- Multiplication:
  - a=0x0A, b=0x03, mul → busy high for 9 cycles; result=0x001E.
  - a=0xFF, b=0xFF, mul → result=0xFE01.
- Division:
  - a=0x0A, b=0x03, div → L=9; result=0x0003, remainder=0x01.
  - a=0x0A, b=0x00, div → L=1; err_div0=1, result=0.
  - A following successful add → err_div0 returns to 0.
- Start during busy, start held continuously:
  - mul started, `start` re-pulsed with op=add at cycle 3 → ignored; only the mul result (0x001E) appears, with a single `done`.
  - `start` held continuously → successive operations complete every L+1 cycles.
- Reset mid-operation: CPU_RESETN pulsed low at cycle 4 of a div → all outputs 0 immediately; no `done` pulse; a subsequent add completes normally.
